// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio input filter: register offsets and bus decode.
package gpio_pkg;

  localparam logic [7:0] FLT_FILT   = 8'h00;
  localparam logic [7:0] FLT_RISE   = 8'h04;
  localparam logic [7:0] FLT_FALL   = 8'h08;
  localparam logic [7:0] FLT_PEND   = 8'h0C;
  localparam logic [7:0] FLT_THRESH = 8'h10;

  localparam int unsigned DEFAULT_CNT_W = 16;

  typedef enum logic [2:0] {
    REG_FILT,
    REG_RISE,
    REG_FALL,
    REG_PEND,
    REG_THRESH,
    REG_NONE
  } flt_reg_e;

  function automatic flt_reg_e reg_decode(input logic [7:0] off);
    case (off)
      FLT_FILT:   return REG_FILT;
      FLT_RISE:   return REG_RISE;
      FLT_FALL:   return REG_FALL;
      FLT_PEND:   return REG_PEND;
      FLT_THRESH: return REG_THRESH;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_in_filter_if.sv
// Single-cycle ce/we/addr register bus shared by the peripherals.
interface gpio_in_filter_if;
  logic        flt_ce_i;
  logic        flt_we_i;
  logic [31:0] flt_addr_i;
  logic [31:0] flt_data_i;
  logic        flt_ack_o;
  logic [31:0] flt_data_o;

  modport master (
    output flt_ce_i, flt_we_i, flt_addr_i, flt_data_i,
    input  flt_ack_o, flt_data_o
  );

  modport slave (
    input  flt_ce_i, flt_we_i, flt_addr_i, flt_data_i,
    output flt_ack_o, flt_data_o
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One pin: synchroniser chain, stable-count debounce and edge strobes.
module gpio_debounce_bit #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad,
  input  logic [CNT_W-1:0] thresh,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   flip;

  assign s = sync[SYNC_STAGES-1];

  // rise/fall strobe in the cycle whose closing edge updates level
  assign flip = (s != level) && (cnt >= thresh);
  assign rise = flip & s;
  assign fall = flip & ~s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
      if (s == level || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (flip) begin
        level <= s;
      end
    end
  end

endmodule

// File: rtl/gpio_in_filter.sv
// Pad input conditioning: per-pin debounce, edge-pending latch, level irq, register bus.
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int unsigned NPINS       = 32,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  gpio_in_filter_if.slave  flt,
  input  logic [NPINS-1:0] pad_i,
  output logic [NPINS-1:0] pin_o,
  output logic             irq_o
);

  logic [NPINS-1:0] rise, fall;
  logic [NPINS-1:0] rise_en, fall_en, pend, pend_next, w1c;
  logic [CNT_W-1:0] thresh;
  logic             rvalid;
  logic             wr, rd;
  logic [31:0]      rdata;
  flt_reg_e         sel;
  logic             unused_bits;

  for (genvar g = 0; g < NPINS; g++) begin : g_pin
    gpio_debounce_bit #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bit (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .pad    (pad_i[g]),
      .thresh (thresh),
      .level  (pin_o[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  assign sel = reg_decode(flt.flt_addr_i[7:0]);
  assign wr  = flt.flt_ce_i &  flt.flt_we_i;
  assign rd  = flt.flt_ce_i & ~flt.flt_we_i;

  // a fresh edge outranks a same-cycle clear of that bit
  assign w1c       = (wr && sel == REG_PEND) ? flt.flt_data_i[NPINS-1:0] : '0;
  assign pend_next = (pend & ~w1c) | (rise & rise_en) | (fall & fall_en);

  assign flt.flt_ack_o = flt.flt_ce_i & (flt.flt_we_i | rvalid);
  assign unused_bits   = ^{flt.flt_addr_i[31:8], flt.flt_data_i};

  always_comb begin
    rdata = '0;
    case (sel)
      REG_FILT:   rdata[NPINS-1:0] = pin_o;
      REG_RISE:   rdata[NPINS-1:0] = rise_en;
      REG_FALL:   rdata[NPINS-1:0] = fall_en;
      REG_PEND:   rdata[NPINS-1:0] = pend;
      REG_THRESH: rdata[CNT_W-1:0] = thresh;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_en        <= '0;
      fall_en        <= '0;
      pend           <= '0;
      thresh         <= '0;
      irq_o          <= 1'b0;
      rvalid         <= 1'b0;
      flt.flt_data_o <= '0;
    end else begin
      pend  <= pend_next;
      irq_o <= |(pend_next & (rise_en | fall_en));
      if (wr && sel == REG_RISE)   rise_en <= flt.flt_data_i[NPINS-1:0];
      if (wr && sel == REG_FALL)   fall_en <= flt.flt_data_i[NPINS-1:0];
      if (wr && sel == REG_THRESH) thresh  <= flt.flt_data_i[CNT_W-1:0];
      rvalid         <= rd;
      flt.flt_data_o <= rd ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Randomised + directed bench for gpio_in_filter against a cycle-timestamp reference model.
module tb_gpio_in_filter;

  localparam int NP = 32;
  localparam int CW = 16;
  localparam int SS = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NP-1:0] pad_i;
  logic [NP-1:0] pin_o;
  logic          irq_o;

  gpio_in_filter_if bus();

  gpio_in_filter #(.NPINS(NP), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flt   (bus),
    .pad_i (pad_i),
    .pin_o (pin_o),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint due; logic [31:0] data; } rd_t;
  rd_t rq[$];
  rd_t mon_e;

  logic [NP-1:0] m_hist [SS];
  logic [NP-1:0] m_pin, m_ren, m_fen, m_pend, ms, mr, mf, mnx, mw1c;
  logic [CW-1:0] m_thr;
  logic          m_irq, m_rvalid, mwr, mrd;
  logic [7:0]    ma;
  longint        m_start [NP];   // cycle at which the current mismatch streak began, -1 if none
  longint        cyc = 0;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_pin;
      8'h04:   return m_ren;
      8'h08:   return m_fen;
      8'h0C:   return m_pend;
      8'h10:   return 32'(m_thr);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      for (int i = 0; i < NP; i++) m_start[i] = -1;
      m_pin = '0; m_ren = '0; m_fen = '0; m_pend = '0; m_thr = '0;
      m_irq = 1'b0; m_rvalid = 1'b0;
      rq.delete();
    end else begin
      cyc++;
      ms = m_hist[SS-1];
      mr = '0;
      mf = '0;
      for (int i = 0; i < NP; i++) begin
        if (ms[i] == m_pin[i]) m_start[i] = -1;
        else begin
          if (m_start[i] < 0) m_start[i] = cyc;
          if (cyc - m_start[i] >= longint'(m_thr)) begin
            if (ms[i]) mr[i] = 1'b1; else mf[i] = 1'b1;
            m_start[i] = -1;
          end
        end
      end
      ma   = bus.flt_addr_i[7:0];
      mwr  = bus.flt_ce_i & bus.flt_we_i;
      mrd  = bus.flt_ce_i & ~bus.flt_we_i;
      mw1c = (mwr && ma == 8'h0C) ? bus.flt_data_i : '0;
      mnx  = (m_pend & ~mw1c) | (mr & m_ren) | (mf & m_fen);
      m_irq = |(mnx & (m_ren | m_fen));
      if (mrd) rq.push_back('{cyc, m_read(ma)});
      m_rvalid = mrd;
      m_pin  = m_pin ^ (mr | mf);
      m_pend = mnx;
      if (mwr && ma == 8'h04) m_ren = bus.flt_data_i;
      if (mwr && ma == 8'h08) m_fen = bus.flt_data_i;
      if (mwr && ma == 8'h10) m_thr = bus.flt_data_i[CW-1:0];
      for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = pad_i;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      chk("pin_o", pin_o, m_pin);
      chk("irq_o", 32'(irq_o), 32'(m_irq));
      chk("ack", 32'(bus.flt_ack_o), 32'(bus.flt_ce_i & (bus.flt_we_i | m_rvalid)));
      if (rq.size() > 0 && rq[0].due == cyc) begin
        mon_e = rq.pop_front();
        chk("rdata", bus.flt_data_o, mon_e.data);
      end else begin
        chk("rdata_idle", bus.flt_data_o, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    bus.flt_ce_i = 1'b1; bus.flt_we_i = 1'b1;
    bus.flt_addr_i = {24'h0, a}; bus.flt_data_i = d;
    #1 chk("wr_ack", 32'(bus.flt_ack_o), 32'h1);
    tick();
    bus.flt_ce_i = 1'b0; bus.flt_we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    bus.flt_ce_i = 1'b1; bus.flt_we_i = 1'b0;
    bus.flt_addr_i = {24'h0, a};
    #1 chk("rd_ack_first", 32'(bus.flt_ack_o), 32'h0);
    tick();
    #1 chk("rd_ack_second", 32'(bus.flt_ack_o), 32'h1);
    d = bus.flt_data_o;
    bus.flt_ce_i = 1'b0;
    tick();
  endtask

  logic [31:0] v;
  logic [7:0]  addrs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'hFC};
  logic [7:0]  ra;
  logic [31:0] rd_data;
  int unsigned sel_r;

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    pad_i = '0;
    bus.flt_ce_i = 1'b0; bus.flt_we_i = 1'b0;
    bus.flt_addr_i = '0; bus.flt_data_i = '0;
    tick(3);
    rst_i = 1'b0;
    tick(4);

    // asynchronous reset mid-run, then release with thresh=0
    bus_wr(8'h04, 32'hFFFF_FFFF);
    pad_i = '1;
    tick(6);
    chk("irq_before_reset", 32'(irq_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk("reset_pin", pin_o, 32'h0);
    chk("reset_irq", 32'(irq_o), 32'h0);
    tick();
    rst_i = 1'b0;
    tick(2);
    chk("release_2cyc", pin_o, 32'h0);
    tick();
    chk("release_3cyc", pin_o, 32'hFFFF_FFFF);

    // debounce with thresh=4
    bus_wr(8'h10, 32'd4);
    pad_i = '0;
    tick(10);
    pad_i[0] = 1'b1;
    tick(4);
    pad_i[0] = 1'b0;
    tick(10);
    chk("glitch_rejected", 32'(pin_o[0]), 32'h0);
    pad_i[0] = 1'b1;
    tick(6);
    chk("debounce_6cyc", 32'(pin_o[0]), 32'h0);
    tick();
    chk("debounce_7cyc", 32'(pin_o[0]), 32'h1);

    // edge pending and irq
    bus_wr(8'h10, 32'd0);
    bus_wr(8'h04, 32'h1);
    bus_wr(8'h08, 32'h2);
    pad_i[0] = 1'b0;
    tick(5);
    bus_wr(8'h0C, 32'hFFFF_FFFF);
    chk("irq_cleared", 32'(irq_o), 32'h0);
    pad_i[0] = 1'b1;
    tick(3);
    chk("irq_on_rise", 32'(irq_o), 32'h1);
    bus_rd(8'h0C, v);
    chk("pend_rise", v, 32'h1);
    pad_i[1] = 1'b1;
    tick(4);
    pad_i[1] = 1'b0;
    tick(4);
    bus_rd(8'h0C, v);
    chk("pend_fall", v, 32'h3);
    bus_wr(8'h0C, 32'h1);
    bus_rd(8'h0C, v);
    chk("pend_w1c_bit0", v, 32'h2);
    chk("irq_still_set", 32'(irq_o), 32'h1);
    bus_wr(8'h0C, 32'h2);
    chk("irq_all_clear", 32'(irq_o), 32'h0);

    // W1C colliding with a new rise on the same bit
    pad_i[0] = 1'b0;
    tick(4);
    pad_i[0] = 1'b1;
    tick(2);
    bus_wr(8'h0C, 32'h1);
    bus_rd(8'h0C, v);
    chk("set_beats_w1c", v, 32'h1);
    bus_wr(8'h0C, 32'hFFFF_FFFF);

    // bus timing and unmapped offset
    bus_wr(8'h10, 32'hABCD_00FF);
    bus_rd(8'h10, v);
    chk("thresh_readback", v, 32'h0000_00FF);
    bus_rd(8'h14, v);
    chk("unmapped_read", v, 32'h0);

    // lowering the threshold mid-count
    bus_wr(8'h10, 32'd100);
    pad_i[2] = 1'b1;
    tick(52);
    chk("thr100_hold", 32'(pin_o[2]), 32'h0);
    bus_wr(8'h10, 32'd10);
    chk("thr_write_edge", 32'(pin_o[2]), 32'h0);
    tick();
    chk("thr_lowered", 32'(pin_o[2]), 32'h1);

    // randomised traffic
    for (int k = 0; k < 1500; k++) begin
      pad_i = pad_i ^ ($urandom & $urandom & $urandom);
      sel_r = $urandom_range(0, 9);
      ra = addrs[$urandom_range(0, 6)];
      if (k == 700) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
      end else if (sel_r == 0) begin
        bus_rd(ra, rd_data);
      end else if (sel_r < 3) begin
        if (ra == 8'h10) bus_wr(ra, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 6)));
        else             bus_wr(ra, $urandom);
      end else begin
        tick();
      end
    end
    tick(5);
    chk("read_queue_drained", 32'(rq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
